l1_dcache: RTL and testbench
============================

Name: l1_dcache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache directly downstream of the CPU datapath's memory stage.
- Serves the memory stage's full-line request interface: 128-bit line data, 16-bit byte enables, request held until response.
- On a miss, evicts a dirty victim and fills the line through a 128-bit physical-memory port, which an icache/dcache arbiter consumes.

Parameters:
- IDX_BITS, 3, index width; number of sets = 2**IDX_BITS (8 by default).
- OFF_BITS, 4, byte-offset width; a line is 16 bytes (128 bits) and this value is fixed by lc3b_datbus.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- mem_req  in  1  request strobe from the datapath; held high until mem_resp.
- mem_we  in  1  1 = write request, 0 = read request; sampled with mem_req.
- mem_addr  in  16  byte address (lc3b_word).
- mem_byte_en  in  16  per-byte write enable over the line.
- mem_wdata  in  128  write data (lc3b_datbus), already replicated across the line.
- mem_resp  out  1  one-cycle completion pulse.
- mem_rdata  out  128  full cached line.
- pmem_addr  out  16  line-aligned address; bits [3:0] = 0.
- pmem_read  out  1  fill request; held until pmem_resp.
- pmem_write  out  1  writeback request; held until pmem_resp.
- pmem_wdata  out  128  victim line data.
- pmem_rdata  in  128  fill data.
- pmem_resp  in  1  one-cycle completion from the arbiter.

Behaviour:
- Address split: tag = addr[15:IDX_BITS+4], index = addr[IDX_BITS+3:4], offset = addr[3:0].
- Hit = valid[index] && tag_array[index] == tag.

State machine: IDLE, WRITEBACK, FILL.
- IDLE, no request: idle.
- IDLE, mem_req && hit: mem_resp = 1 combinationally in the same cycle.
  - Read hit: mem_rdata = line[index].
  - Write hit: on the clock edge, each byte i with mem_byte_en[i] = 1 is overwritten by mem_wdata byte i. Dirty is set only if mem_byte_en != 0.
  - Stay in IDLE.
- IDLE, mem_req && !hit && dirty[index]: go to WRITEBACK.
- IDLE, mem_req && !hit && !dirty[index]: go to FILL.
- WRITEBACK: pmem_write = 1; pmem_addr = {tag_array[index], index, 4'h0}; pmem_wdata = line[index]. On pmem_resp, clear dirty and go to FILL.
- FILL: pmem_read = 1; pmem_addr = {tag, index, 4'h0}. On pmem_resp, write pmem_rdata into the line, write the tag, set valid, clear dirty, and go to IDLE.
  - The next cycle re-evaluates as a hit and pulses mem_resp. The pending write merge happens then.

Latency:
- Hit: 0 cycles.
- Clean miss: Tfill + 1 cycles.
- Dirty miss: Twb + Tfill + 1 cycles.

Outputs and conditions:
- mem_rdata is valid only while mem_resp = 1; otherwise it is line[index] and carries no meaning.
- pmem_read and pmem_write are never asserted together. Each is combinational from state only.
- pmem_resp in IDLE is ignored.
- If mem_req drops during WRITEBACK or FILL, the miss still completes and the line is installed. No mem_resp is issued unless mem_req is high in IDLE.
- If mem_addr changes while mem_req is held, that is a protocol violation and the result is undefined. The bench asserts that this never happens.

Reset (asynchronous, any state):
- state = IDLE; all valid = 0; all dirty = 0.
- mem_resp = 0, pmem_read = 0, pmem_write = 0, pmem_addr = 0.
- Data and tag arrays are not reset.
- Reset mid-fill or mid-writeback abandons the transfer immediately. The arbiter must tolerate the request dropping.

Decomposition:
- lc3b_types additions: lc3b_c_tag (logic [8:0]), lc3b_c_index (logic [2:0]), lc3b_c_offset (logic [3:0]), and an enum lc3b_dcache_state {s_idle, s_writeback, s_fill}. lc3b_datbus is reused.
- Sub-module l1d_line_array holds tag, valid, dirty and data registers. It provides an async read port and a synchronous byte-masked write port, and has its own asynchronous clear of valid/dirty.
- l1_dcache holds the FSM, the hit compare and the write-merge logic.

Test Plan:
- Cold read: after reset, read 0x1234 with pmem_resp given 3 cycles after pmem_read. Required: pmem_addr = 0x1230, then mem_resp one cycle after the fill, mem_rdata = fill data, no pmem_write.
- Read hit: repeat the read of 0x1236. Required: mem_resp in the same cycle as mem_req, no pmem activity.
- Write hit partial: write 0x1234 with byte_en = 0x0030 and wdata = {8{16'hBEEF}}. Then read 0x1234. Required: bytes 4-5 = EF/BE, other bytes unchanged.
- Dirty eviction: read 0x12B4 (same index 3, different tag). Required:
  - pmem_write with pmem_addr = 0x1230 and pmem_wdata = the merged line;
  - then pmem_read with pmem_addr = 0x12B0;
  - then mem_resp;
  - a later read of 0x1234 triggers a clean miss with no writeback.
- Zero-mask write: write 0x2000 with byte_en = 0x0000 after a fill. Required: mem_resp, line unchanged; a later conflicting miss issues no pmem_write.
- Reset mid-fill: assert rst two cycles into FILL. Required: pmem_read = 0 immediately, all valid = 0, and a re-read of the same address misses again.

Source files
------------

// File: rtl/l1_dcache_pkg.sv
// Shared types for the L1 data cache: address fields, line bus, FSM states
// and the byte-merge helper used by the line array.
package l1_dcache_pkg;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int BE_W   = LINE_W / 8;

  typedef logic [ADDR_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_datbus;
  typedef logic [8:0]        lc3b_c_tag;
  typedef logic [2:0]        lc3b_c_index;
  typedef logic [3:0]        lc3b_c_offset;

  typedef enum logic [1:0] {
    s_idle,
    s_writeback,
    s_fill
  } lc3b_dcache_state;

  function automatic lc3b_datbus merge_bytes(input lc3b_datbus old_line,
                                             input lc3b_datbus new_line,
                                             input logic [BE_W-1:0] be);
    lc3b_datbus res;
    res = old_line;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_line[8*b +: 8];
    end
    return res;
  endfunction
endpackage

// File: rtl/l1d_line_array.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous byte-masked write.
// Only valid and dirty are cleared by reset; data and tags keep stale contents.
module l1d_line_array
  import l1_dcache_pkg::*;
#(
  parameter int IDX_BITS = 3,
  parameter int TAG_BITS = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] idx,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty,
  output lc3b_datbus          rd_data,
  input  logic [BE_W-1:0]     wr_be,
  input  lc3b_datbus          wr_data,
  input  logic                wr_tag_en,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic                set_valid,
  input  logic                set_dirty,
  input  logic                clr_dirty
);
  localparam int SETS = 2 ** IDX_BITS;

  lc3b_datbus          data_q [SETS];
  lc3b_datbus          data_d [SETS];
  logic [TAG_BITS-1:0] tag_q  [SETS];
  logic [TAG_BITS-1:0] tag_d  [SETS];
  logic [SETS-1:0]     valid_q, valid_d;
  logic [SETS-1:0]     dirty_q, dirty_d;

  assign rd_tag   = tag_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_data  = data_q[idx];

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    data_d[idx] = merge_bytes(data_q[idx], wr_data, wr_be);
    if (wr_tag_en) tag_d[idx] = wr_tag;
    if (set_valid) valid_d[idx] = 1'b1;
    // A fill both installs and cleans the line, so clear wins over set.
    if (clr_dirty)      dirty_d[idx] = 1'b0;
    else if (set_dirty) dirty_d[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end
endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back, write-allocate L1 data cache: FSM, hit compare
// and write merge in front of a 128-bit physical-memory port.
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter int IDX_BITS = 3,
  parameter int OFF_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  lc3b_word    mem_addr,
  input  logic [15:0] mem_byte_en,
  input  lc3b_datbus  mem_wdata,
  output logic        mem_resp,
  output lc3b_datbus  mem_rdata,
  output lc3b_word    pmem_addr,
  output logic        pmem_read,
  output logic        pmem_write,
  output lc3b_datbus  pmem_wdata,
  input  lc3b_datbus  pmem_rdata,
  input  logic        pmem_resp
);
  localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS;

  lc3b_dcache_state    state_q, state_d;
  logic [TAG_BITS-1:0] req_tag, line_tag;
  logic [IDX_BITS-1:0] req_idx;
  logic                line_valid, line_dirty, hit;
  lc3b_datbus          line_data, wr_data;
  logic [BE_W-1:0]     wr_be;
  logic                wr_tag_en, set_valid, set_dirty, clr_dirty;
  logic                unused_offset;

  assign req_tag       = mem_addr[ADDR_W-1 -: TAG_BITS];
  assign req_idx       = mem_addr[OFF_BITS +: IDX_BITS];
  assign unused_offset = ^mem_addr[OFF_BITS-1:0];
  assign hit           = line_valid && (line_tag == req_tag);

  // Fill data replaces the whole line; otherwise the CPU write data is merged.
  assign wr_data    = (state_q == s_fill) ? pmem_rdata : mem_wdata;
  assign mem_rdata  = line_data;
  assign pmem_wdata = line_data;

  l1d_line_array #(
    .IDX_BITS(IDX_BITS),
    .TAG_BITS(TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .idx      (req_idx),
    .rd_tag   (line_tag),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_data  (line_data),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .wr_tag_en(wr_tag_en),
    .wr_tag   (req_tag),
    .set_valid(set_valid),
    .set_dirty(set_dirty),
    .clr_dirty(clr_dirty)
  );

  always_comb begin
    state_d    = state_q;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    wr_be      = '0;
    wr_tag_en  = 1'b0;
    set_valid  = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    unique case (state_q)
      s_idle: begin
        if (mem_req && hit) begin
          mem_resp = 1'b1;
          if (mem_we) begin
            wr_be     = mem_byte_en;
            set_dirty = |mem_byte_en;
          end
        end else if (mem_req) begin
          state_d = line_dirty ? s_writeback : s_fill;
        end
      end
      s_writeback: begin
        pmem_write = 1'b1;
        pmem_addr  = {line_tag, req_idx, {OFF_BITS{1'b0}}};
        if (pmem_resp) begin
          clr_dirty = 1'b1;
          state_d   = s_fill;
        end
      end
      s_fill: begin
        pmem_read = 1'b1;
        pmem_addr = {req_tag, req_idx, {OFF_BITS{1'b0}}};
        if (pmem_resp) begin
          wr_be     = '1;
          wr_tag_en = 1'b1;
          set_valid = 1'b1;
          clr_dirty = 1'b1;
          state_d   = s_idle;
        end
      end
      default: state_d = s_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= s_idle;
    else     state_q <= state_d;
  end
endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: a line-level reference model predicts each
// response, pushed to a scoreboard queue and popped when mem_resp arrives.
module tb_l1_dcache;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_req = 1'b0;
  logic         mem_we = 1'b0;
  logic [15:0]  mem_addr = '0;
  logic [15:0]  mem_byte_en = '0;
  logic [127:0] mem_wdata = '0;
  logic         mem_resp;
  logic [127:0] mem_rdata;
  logic [15:0]  pmem_addr;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [127:0] sb[$];
  logic [127:0] m_data [8];
  logic [8:0]   m_tag  [8];
  logic         m_valid[8];
  logic         m_dirty[8];

  always #5 clk = ~clk;

  l1_dcache dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_byte_en(mem_byte_en),
    .mem_wdata  (mem_wdata),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata),
    .pmem_addr  (pmem_addr),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The address must stay stable while a request is outstanding.
  logic        prev_req = 1'b0;
  logic        prev_resp = 1'b0;
  logic [15:0] prev_addr = '0;
  always @(posedge clk) begin
    if (mem_req && prev_req && !prev_resp) begin
      tests++;
      assert (mem_addr === prev_addr) else begin
        fails++;
        $error("FAIL addr_stable: observed %h expected %h", mem_addr, prev_addr);
      end
    end
    prev_req  = mem_req;
    prev_resp = mem_resp;
    prev_addr = mem_addr;
  end

  function automatic logic [127:0] merge(input logic [127:0] o, input logic [127:0] n,
                                         input logic [15:0] be);
    logic [127:0] r;
    r = o;
    for (int b = 0; b < 16; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One CPU request; arbiter answers each pmem request on its third cycle.
  task automatic req(input string name, input logic we, input logic [15:0] addr,
                     input logic [15:0] be, input logic [127:0] wd,
                     output logic [127:0] obs);
    logic [2:0]   i;
    logic [8:0]   t;
    logic         hit, exp_wb, wb_seen, fill_seen, done;
    logic [127:0] fill, exp_rd;
    int           cyc, wcnt, rcnt, exp_lat;
    i = addr[6:4];
    t = addr[15:7];
    hit    = m_valid[i] && (m_tag[i] == t);
    exp_wb = !hit && m_dirty[i];
    fill   = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_rd = hit ? m_data[i] : fill;
    exp_lat = hit ? 0 : (exp_wb ? 7 : 4);
    sb.push_back(exp_rd);
    obs = '0;
    wb_seen = 1'b0; fill_seen = 1'b0; done = 1'b0;
    cyc = 0; wcnt = 0; rcnt = 0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_byte_en = be; mem_wdata = wd;
    #1;
    while (!done && cyc < 100) begin
      if (pmem_read && pmem_write) chk({name, "_rd_wr_excl"}, 1'b1, 1'b0);
      if (mem_resp) begin
        obs = mem_rdata;
        chk({name, "_rdata"}, mem_rdata, sb.pop_front());
        pmem_resp = 1'b0;
        done = 1'b1;
      end else begin
        if (pmem_write) begin
          if (!wb_seen) begin
            chk({name, "_wb_addr"}, pmem_addr, {m_tag[i], i, 4'h0});
            chk({name, "_wb_data"}, pmem_wdata, m_data[i]);
          end
          wb_seen = 1'b1;
          wcnt++;
          pmem_resp = (wcnt == 3);
        end else if (pmem_read) begin
          if (!fill_seen) chk({name, "_fill_addr"}, pmem_addr, {t, i, 4'h0});
          fill_seen = 1'b1;
          rcnt++;
          pmem_rdata = fill;
          pmem_resp = (rcnt == 3);
        end else begin
          pmem_resp = 1'b0;
        end
        @(negedge clk);
        #1;
        cyc++;
      end
    end
    if (!done) begin
      chk({name, "_timeout"}, 1'b1, 1'b0);
      sb.delete();
      pmem_resp = 1'b0;
    end
    chk({name, "_latency"}, 128'(cyc), 128'(exp_lat));
    chk({name, "_wb_seen"}, wb_seen, exp_wb);
    chk({name, "_fill_seen"}, fill_seen, !hit);
    @(negedge clk);
    mem_req = 1'b0;
    mem_we = 1'b0;
    if (!hit) begin
      m_data[i] = fill; m_tag[i] = t; m_valid[i] = 1'b1; m_dirty[i] = 1'b0;
    end
    if (we) begin
      m_data[i] = merge(m_data[i], wd, be);
      if (|be) m_dirty[i] = 1'b1;
    end
  endtask

  initial begin
    logic [127:0] obs, fill1, beef, mask45;
    beef   = {8{16'hBEEF}};
    mask45 = ~(128'hFFFF << 32);
    model_clear();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_resp", mem_resp, 1'b0);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_addr", pmem_addr, 16'h0);
    rst = 1'b0;

    // Cold read, read hit, partial write hit, read back
    req("cold_read", 1'b0, 16'h1234, 16'h0, '0, fill1);
    req("read_hit", 1'b0, 16'h1236, 16'h0, '0, obs);
    req("write_hit", 1'b1, 16'h1234, 16'h0030, beef, obs);
    req("read_merged", 1'b0, 16'h1234, 16'h0, '0, obs);
    chk("merged_bytes45", obs[47:32], 16'hBEEF);
    chk("merged_others", obs & mask45, fill1 & mask45);

    // Dirty eviction, then the old line comes back clean
    req("dirty_evict", 1'b0, 16'h12B4, 16'h0, '0, obs);
    req("reload_clean", 1'b0, 16'h1234, 16'h0, '0, obs);

    // Zero-mask write leaves the line clean and unchanged
    req("zm_fill", 1'b0, 16'h2000, 16'h0, '0, fill1);
    req("zm_write", 1'b1, 16'h2000, 16'h0000, beef, obs);
    req("zm_readback", 1'b0, 16'h2000, 16'h0, '0, obs);
    chk("zm_unchanged", obs, fill1);
    req("zm_conflict", 1'b0, 16'h2080, 16'h0, '0, obs);

    // Write miss allocates, then merges full line
    req("write_miss", 1'b1, 16'h3454, 16'hFFFF, beef, obs);
    req("write_miss_rd", 1'b0, 16'h3454, 16'h0, '0, obs);
    chk("write_miss_data", obs, beef);

    // Reset two cycles into FILL
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h4444; mem_byte_en = '0;
    #1 chk("mid_idle_noresp", mem_resp, 1'b0);
    @(negedge clk);
    #1 chk("mid_fill_read", pmem_read, 1'b1);
    chk("mid_fill_addr", pmem_addr, 16'h4440);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_pmem_read", pmem_read, 1'b0);
    chk("mid_rst_pmem_write", pmem_write, 1'b0);
    chk("mid_rst_pmem_addr", pmem_addr, 16'h0);
    chk("mid_rst_mem_resp", mem_resp, 1'b0);
    mem_req = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Every line is invalid and clean again
    req("post_rst_reread", 1'b0, 16'h4444, 16'h0, '0, obs);
    req("post_rst_oldline", 1'b0, 16'h1234, 16'h0, '0, obs);
    req("post_rst_wasdirty", 1'b0, 16'h3454, 16'h0, '0, obs);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
